// File: rtl/video_frame_sync_ctrl.sv
// Frame-start controller: on each camera vsync it clears the video FIFO, waits for a
// prefill level, then releases the timing generator and supervises the stream for underflow.
module video_frame_sync_ctrl #(
  parameter int unsigned FIFO_RST_CYCLES = 4,
  parameter int unsigned PREFILL         = 16,
  parameter int unsigned LEVEL_W         = 11,
  parameter int unsigned TIMEOUT         = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cam_vs,
  input  logic [LEVEL_W-1:0] fifo_rd_level,
  input  logic               fifo_empty,
  input  logic               tg_de,
  output logic               fifo_rst,
  output logic               tg_run,
  output logic               fifo_rd_en,
  output logic               locked,
  output logic               underflow,
  output logic [15:0]        frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    FILL = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic [7:0]  CLR_LAST  = 8'(FIFO_RST_CYCLES - 1);
  localparam logic [15:0] FILL_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        s1, s2, s3;
  logic        sync_valid;
  logic        vs_armed;
  logic        vs_rise;
  logic        level_ok;
  logic        enter_clr;
  logic        enter_fill;
  logic        uf_nxt;
  logic [7:0]  clr_cnt;
  logic [15:0] fill_cnt;

  // vs_armed requires a genuine low sample of cam_vs after reset, so a vsync that is
  // already high at release cannot masquerade as a rising edge.
  assign vs_rise  = s2 & ~s3 & vs_armed;
  assign level_ok = 32'(fifo_rd_level) >= PREFILL;

  assign fifo_rst   = (state == CLR);
  assign tg_run     = (state == RUN);
  assign fifo_rd_en = tg_de & tg_run & ~fifo_empty;

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: if (vs_rise) state_nxt = CLR;
      CLR:  if (clr_cnt == CLR_LAST) state_nxt = FILL;
      FILL: begin
        if (level_ok)                    state_nxt = RUN;
        else if (vs_rise)                state_nxt = CLR;
        else if (fill_cnt == FILL_LAST)  state_nxt = IDLE;
      end
      RUN:  if (vs_rise) state_nxt = CLR;
      default: state_nxt = IDLE;
    endcase
    enter_clr  = (state_nxt == CLR)  && (state != CLR);
    enter_fill = (state_nxt == FILL) && (state != FILL);
    uf_nxt     = enter_clr ? 1'b0 : (underflow | ((state == RUN) & tg_de & fifo_empty));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      sync_valid <= 1'b0;
      vs_armed   <= 1'b0;
      clr_cnt    <= '0;
      fill_cnt   <= '0;
      underflow  <= 1'b0;
      locked     <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      s1         <= cam_vs;
      s2         <= s1;
      s3         <= s2;
      sync_valid <= 1'b1;
      vs_armed   <= vs_armed | (sync_valid & ~s1);
      state      <= state_nxt;

      if (enter_clr)          clr_cnt <= '0;
      else if (state == CLR)  clr_cnt <= clr_cnt + 8'd1;

      if (enter_fill)         fill_cnt <= '0;
      else if (state == FILL) fill_cnt <= fill_cnt + 16'd1;

      underflow <= uf_nxt;
      // locked is computed from next-state values so it lines up with the state register.
      locked    <= (state_nxt == RUN) & ~uf_nxt;

      if (enter_clr) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_video_frame_sync_ctrl.sv
// Directed bench for video_frame_sync_ctrl: a default instance plus a TIMEOUT=8 instance
// sharing the same stimulus.
module tb_video_frame_sync_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cam_vs;
  logic [10:0] fifo_rd_level;
  logic        fifo_empty;
  logic        tg_de;

  logic        fifo_rst, tg_run, fifo_rd_en, locked, underflow;
  logic [15:0] frame_cnt;
  logic        fifo_rst_t, tg_run_t, fifo_rd_en_t, locked_t, underflow_t;
  logic [15:0] frame_cnt_t;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  video_frame_sync_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cam_vs(cam_vs), .fifo_rd_level(fifo_rd_level),
    .fifo_empty(fifo_empty), .tg_de(tg_de), .fifo_rst(fifo_rst), .tg_run(tg_run),
    .fifo_rd_en(fifo_rd_en), .locked(locked), .underflow(underflow), .frame_cnt(frame_cnt)
  );

  video_frame_sync_ctrl #(.TIMEOUT(8)) dut_to (
    .clk(clk), .rst_n(rst_n), .cam_vs(cam_vs), .fifo_rd_level(fifo_rd_level),
    .fifo_empty(fifo_empty), .tg_de(tg_de), .fifo_rst(fifo_rst_t), .tg_run(tg_run_t),
    .fifo_rd_en(fifo_rd_en_t), .locked(locked_t), .underflow(underflow_t),
    .frame_cnt(frame_cnt_t)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cam_vs = 1'b0; fifo_rd_level = '0; fifo_empty = 1'b1; tg_de = 1'b0;
    #1;
    check("rst_fifo_rst",  fifo_rst,  0);
    check("rst_tg_run",    tg_run,    0);
    check("rst_locked",    locked,    0);
    check("rst_underflow", underflow, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    step(2);
    rst_n = 1'b1;
    step(3);

    // Timeout: level stays 0, the TIMEOUT=8 instance must fall back to IDLE
    cam_vs = 1'b1;
    step(2);
    check("to_sync_latency", fifo_rst_t, 0);
    step(1);
    check("to_clr_entry",    fifo_rst_t, 1);
    check("to_frame_cnt",    frame_cnt_t, 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("to_clr_hold", fifo_rst_t, 1);
    end
    step(1);
    check("to_fill_entry", fifo_rst_t, 0);
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("to_fill_tg_run", tg_run_t, 0);
    end
    step(1);
    // Timeout instance should now be in IDLE; the default one is still in FILL
    fifo_rd_level = 11'd16;
    step(1);
    check("to_idle_no_run",  tg_run_t,    0);
    check("to_frame_cnt2",   frame_cnt_t, 1);
    check("def_fill_to_run", tg_run,      1);
    check("def_locked",      locked,      1);

    // Asynchronous reset mid-RUN, between edges
    rst_n = 1'b0;
    #2;
    check("arst_tg_run",    tg_run,    0);
    check("arst_locked",    locked,    0);
    check("arst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // cam_vs still high after release must not trigger a clear
    step(6);
    check("held_vs_fifo_rst",  fifo_rst,  0);
    check("held_vs_frame_cnt", frame_cnt, 0);
    cam_vs = 1'b0; fifo_empty = 1'b0;
    step(3);

    // Nominal start
    cam_vs = 1'b1;
    step(2);
    check("nom_sync_latency", fifo_rst, 0);
    step(1);
    check("nom_clr_fifo_rst",  fifo_rst,  1);
    check("nom_clr_tg_run",    tg_run,    0);
    check("nom_clr_frame_cnt", frame_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("nom_clr_hold", fifo_rst, 1);
    end
    step(1);
    check("nom_fill_fifo_rst", fifo_rst, 0);
    check("nom_fill_tg_run",   tg_run,   0);
    step(1);
    check("nom_run_tg_run", tg_run, 1);
    check("nom_run_locked", locked, 1);

    // Read enable and underflow
    tg_de = 1'b1;
    #1;
    check("rd_en_active", fifo_rd_en, 1);
    fifo_empty = 1'b1;
    #1;
    check("rd_en_empty", fifo_rd_en, 0);
    step(1);
    check("uf_set",        underflow, 1);
    check("uf_locked_low", locked,    0);
    check("uf_still_run",  tg_run,    1);
    tg_de = 1'b0; fifo_empty = 1'b0; cam_vs = 1'b0;
    step(2);
    check("uf_sticky", underflow, 1);

    // Realign from RUN
    cam_vs = 1'b1;
    step(2);
    check("ra_pre_run", tg_run, 1);
    step(1);
    check("ra_fifo_rst",   fifo_rst,  1);
    check("ra_tg_run",     tg_run,    0);
    check("ra_frame_cnt",  frame_cnt, 2);
    check("ra_uf_clear",   underflow, 0);
    check("ra_locked_low", locked,    0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("ra_clr_hold", fifo_rst, 1);
    end
    step(1);
    check("ra_fill", fifo_rst, 0);
    step(1);
    check("ra_run_tg_run", tg_run, 1);
    check("ra_run_locked", locked, 1);

    // frame_cnt wrap
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    step(1);
    check("wrap_preset", frame_cnt, 16'hFFFF);
    cam_vs = 1'b0; fifo_rd_level = '0;
    step(3);
    cam_vs = 1'b1;
    step(3);
    check("wrap_frame_cnt", frame_cnt, 0);
    check("wrap_clr",       fifo_rst,  1);

    // vs_rise coincides with the level reaching PREFILL while in FILL: RUN wins
    cam_vs = 1'b0;
    step(3);
    cam_vs = 1'b1;
    step(2);
    check("tie_in_fill_rst", fifo_rst, 0);
    check("tie_in_fill_run", tg_run,   0);
    fifo_rd_level = 11'd16;
    step(1);
    check("tie_run_wins",  tg_run,    1);
    check("tie_no_clr",    fifo_rst,  0);
    check("tie_frame_cnt", frame_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
